blink_scheduler: RTL and testbench



---
 rtl/blink_scheduler.sv | 102 ++++++++++
 tb/tb_blink_scheduler.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/blink_scheduler.sv
// blink_scheduler: button-driven mode controller scheduling three tick-divided blink channels onto led[2:0]
// Ports: clk - system clock; rst_n - async active-low reset; button_in - raw button, low = pressed;
//        led - registered LED drive, 1 = on; mode - current mode (0 ALL, 1 CHASE, 2 SYNC, 3 OFF)
module blink_scheduler #(
    parameter int TICK_CYCLES     = 1000000,
    parameter int DIV0            = 100,
    parameter int DIV1            = 10,
    parameter int DIV2            = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_in,
    output logic [2:0] led,
    output logic [1:0] mode
);
    typedef enum logic [1:0] {ALL, CHASE, SYNC, OFF} mode_t;
    localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    mode_t state, state_nx;
    logic s1, btn_s, stable, stable_d, press, tick;
    logic [DW-1:0] db_cnt;
    logic [TW-1:0] presc;
    logic [2:0] ch, ev, pos;
    // press is taken from the delayed stable level so it fires the cycle after stable falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            btn_s <= 1'b1;
            stable <= 1'b1;
            stable_d <= 1'b1;
            press <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1 <= button_in;
            btn_s <= s1;
            stable_d <= stable;
            press <= stable_d & ~stable;
            if (btn_s == stable)
                db_cnt <= '0;
            else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= btn_s;
                db_cnt <= '0;
            end else
                db_cnt <= db_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ALL;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (press)
            state_nx = mode_t'(state + 2'd1);
    end
    assign mode = state;
    assign tick = presc == TW'(TICK_CYCLES - 1);
    // a mode write (press) clears the whole timebase and wins over any tick in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            pos <= 3'b001;
        end else if (press) begin
            presc <= '0;
            pos <= 3'b001;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (ev[0])
                pos <= {pos[1:0], pos[2]};
        end
    end
    for (genvar k = 0; k < 3; k++) begin : g_ch
        localparam int D = k == 0 ? DIV0 : (k == 1 ? DIV1 : DIV2);
        localparam int W = D > 1 ? $clog2(D) : 1;
        logic [W-1:0] cnt;
        logic t;
        assign ev[k] = tick && cnt == W'(D - 1);
        assign ch[k] = t;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                t <= 1'b0;
            end else if (press) begin
                cnt <= '0;
                t <= 1'b0;
            end else if (ev[k]) begin
                cnt <= '0;
                t <= ~t;
            end else if (tick)
                cnt <= cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            led <= 3'b000;
        else
            led <= state == ALL ? ch : state == CHASE ? pos : state == SYNC ? {3{ch[2]}} : 3'b000;
    end
endmodule

// File: tb/tb_blink_scheduler.sv
// tb_blink_scheduler: scoreboard bench for blink_scheduler with small tick/debounce parameters
module tb_blink_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic button_in = 1'b1;
    logic [2:0] led;
    logic [1:0] mode;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    typedef struct {
        int c;
        logic [1:0] m;
        logic [2:0] l;
    } exp_t;
    exp_t q[$];
    logic [4:0] prev = 5'b0;

    blink_scheduler #(
        .TICK_CYCLES(4), .DIV0(4), .DIV1(2), .DIV2(1), .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button_in(button_in), .led(led), .mode(mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    // monitor: every visible change of {mode,led} must match the next expected entry
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n)
            prev = {mode, led};
        else if ({mode, led} !== prev) begin
            prev = {mode, led};
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d mode=%0d led=%b", cyc, mode, led);
            end else begin
                e = q.pop_front();
                if (cyc != e.c || mode !== e.m || led !== e.l) begin
                    failures++;
                    $display("FAIL change got cyc=%0d mode=%0d led=%b want cyc=%0d mode=%0d led=%b",
                             cyc, mode, led, e.c, e.m, e.l);
                end
            end
        end
    end

    function automatic logic [2:0] rev(int n);
        logic [2:0] v;
        v = 3'(n % 8);
        return {v[0], v[1], v[2]};
    endfunction

    task automatic push(input int c, input int m, input logic [2:0] l);
        exp_t e;
        e.c = c;
        e.m = 2'(m);
        e.l = l;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_mode", int'(mode), 0);
        chk("reset_led", int'(led), 0);
        // ALL free-run: led counts up bit-reversed, one step per tick, visible at 4n+1
        for (int n = 1; n <= 11; n++) push(4 * n + 1, 0, rev(n));
        push(47, 1, 3'b110); push(48, 1, 3'b001); push(64, 1, 3'b010); push(80, 1, 3'b100);
        push(96, 1, 3'b001); push(107, 2, 3'b001); push(108, 2, 3'b000); push(112, 2, 3'b111);
        push(116, 2, 3'b000); push(120, 2, 3'b111); push(124, 2, 3'b000); push(128, 2, 3'b111);
        push(131, 3, 3'b111); push(132, 3, 3'b000); push(147, 0, 3'b000); push(152, 0, 3'b100);
        push(156, 0, 3'b010); push(160, 0, 3'b110); push(163, 1, 3'b110); push(164, 1, 3'b001);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(34); button_in = 1'b0;
        wait_cyc(36); button_in = 1'b1;
        wait_cyc(40); button_in = 1'b0;
        wait_cyc(50); button_in = 1'b1;
        wait_cyc(100); button_in = 1'b0;
        wait_cyc(108); button_in = 1'b1;
        wait_cyc(124); button_in = 1'b0;
        wait_cyc(130); button_in = 1'b1;
        wait_cyc(140); button_in = 1'b0;
        wait_cyc(146); button_in = 1'b1;
        wait_cyc(156); button_in = 1'b0;
        wait_cyc(162); button_in = 1'b1;
        wait_cyc(170);
        chk("pending_before_reset", q.size(), 0);
        chk("mode_before_reset", int'(mode), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_mode", int'(mode), 0);
        chk("async_reset_led", int'(led), 0);
        button_in = 1'b0;
        push(5, 0, 3'b100); push(7, 1, 3'b100); push(8, 1, 3'b001); push(24, 1, 3'b010);
        push(31, 2, 3'b010); push(32, 2, 3'b000); push(36, 2, 3'b111);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(6);
        chk("held_through_reset_no_early_advance", int'(mode), 0);
        wait_cyc(12); button_in = 1'b1;
        wait_cyc(20); button_in = 1'b0;
        wait_cyc(22); button_in = 1'b1;
        wait_cyc(24); button_in = 1'b0;
        wait_cyc(30);
        chk("glitch_restarts_debounce", int'(mode), 1);
        wait_cyc(34); button_in = 1'b1;
        wait_cyc(38);
        chk("all_expected_seen", q.size(), 0);
        chk("final_mode", int'(mode), 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
